vga_fb_arbiter: RTL and testbench

- Sequences a single-port 24-bit framebuffer RAM and shares it between two requesters: display refill and a host port.
- The display side keeps a small first-word-fall-through (FWFT) pixel FIFO full. The FIFO head drives vga_controller.color_in, and it is popped by vga_controller.active.
- The host gets the port only in slots the display does not need, mostly during blanking.

---
 rtl/vga_pkg.sv | 13 +
 rtl/pix_fifo.sv | 50 +++++
 rtl/vga_fb_arbiter.sv | 136 +++++++++++++
 tb/tb_vga_fb_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA framebuffer arbiter and its pixel FIFO.
package vga_pkg;

  localparam int COLOR_W = 24;
  localparam logic [COLOR_W-1:0] DEFAULT_UNDERFLOW_COLOR = 24'hFF00FF;

  typedef enum logic [2:0] {IDLE, DISP, HWR, HRD1, HRD2} state_t;

  function automatic int unsigned frame_pixels(input int unsigned h, input int unsigned v);
    return h * v;
  endfunction

endpackage

// File: rtl/pix_fifo.sv
// First-word-fall-through pixel FIFO with synchronous flush and occupancy count.
module pix_fifo import vga_pkg::*; #(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic               pop,
  input  logic               flush,
  input  logic [COLOR_W-1:0] wdata,
  output logic [COLOR_W-1:0] head,
  output logic [CNT_W-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [COLOR_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               do_push;
  logic               do_pop;

  // A push into a full FIFO is only accepted when a pop frees a slot in the same cycle.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Shares a single-port framebuffer RAM between display refill (via a FWFT pixel FIFO)
// and a host port; the display keeps the port for the whole visible line.
module vga_fb_arbiter import vga_pkg::*; #(
  parameter int H_VISIBLE = 1024,
  parameter int V_VISIBLE = 768,
  parameter int ADDR_W = 20,
  parameter int FIFO_DEPTH = 8,
  parameter int LOW_WATER = 2,
  parameter logic [COLOR_W-1:0] UNDERFLOW_COLOR = DEFAULT_UNDERFLOW_COLOR
) (
  input  logic               clk65,
  input  logic               rst_n,
  input  logic               active,
  input  logic               screenend,
  output logic [COLOR_W-1:0] color_out,
  output logic               underflow,
  input  logic               host_req,
  input  logic               host_we,
  input  logic [ADDR_W-1:0]  host_addr,
  input  logic [COLOR_W-1:0] host_wdata,
  output logic               host_ack,
  output logic [COLOR_W-1:0] host_rdata,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_we,
  output logic [COLOR_W-1:0] mem_wdata,
  input  logic [COLOR_W-1:0] mem_rdata,
  output state_t             fsm_state
);

  // Host handshake: host_req with we/addr/wdata held stable until a one-cycle host_ack;
  // a request still high in its own ack cycle is not granted again.

  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int FILL_W = CNT_W + 1;
  localparam logic [ADDR_W:0] PIX_END = (ADDR_W + 1)'(frame_pixels(H_VISIBLE, V_VISIBLE));

  state_t              state;
  logic [ADDR_W:0]     fetch_addr;
  logic                rd_issue;
  logic                rd_ret;
  logic [CNT_W-1:0]    count;
  logic [COLOR_W-1:0]  head;
  logic [FILL_W-1:0]   fill;
  logic                empty;
  logic                push;
  logic                pop;
  logic                disp_need;
  logic                urgent;
  logic                host_go;

  // A display read is in flight while its address is on the port (rd_issue)
  // and in the following cycle while its data returns (rd_ret).
  assign fill      = FILL_W'(count) + FILL_W'(rd_issue) + FILL_W'(rd_ret);
  assign disp_need = (fill < FILL_W'(FIFO_DEPTH)) && (fetch_addr < PIX_END);
  assign urgent    = disp_need && (fill <= FILL_W'(LOW_WATER));
  // Every visible pixel pops the FIFO, so a slot lent to the host mid-line costs a pixel.
  assign host_go   = host_req && !host_ack && !active;

  assign empty     = (count == '0);
  assign push      = rd_ret && !screenend;
  assign pop       = active && !empty;
  assign color_out = !active ? '0 : (empty ? UNDERFLOW_COLOR : head);
  assign fsm_state = state;

  pix_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk65),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (screenend),
    .wdata (mem_rdata),
    .head  (head),
    .count (count)
  );

  always_ff @(posedge clk65 or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      fetch_addr <= '0;
      rd_issue   <= 1'b0;
      rd_ret     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      host_ack   <= 1'b0;
      host_rdata <= '0;
    end else begin
      mem_we   <= 1'b0;
      host_ack <= 1'b0;
      rd_issue <= 1'b0;
      rd_ret   <= rd_issue && !screenend;
      if (screenend) fetch_addr <= '0;
      case (state)
        IDLE, DISP: begin
          if (screenend) begin
            state <= IDLE;
          end else if (urgent || (!host_go && disp_need)) begin
            state      <= DISP;
            mem_addr   <= fetch_addr[ADDR_W-1:0];
            fetch_addr <= fetch_addr + 1'b1;
            rd_issue   <= 1'b1;
          end else if (host_go) begin
            mem_addr <= host_addr;
            if (host_we) begin
              state     <= HWR;
              mem_we    <= 1'b1;
              mem_wdata <= host_wdata;
              host_ack  <= 1'b1;
            end else begin
              state <= HRD1;
            end
          end else begin
            state <= IDLE;
          end
        end
        HWR:  state <= IDLE;
        HRD1: state <= HRD2;
        HRD2: begin
          state      <= IDLE;
          host_ack   <= 1'b1;
          host_rdata <= mem_rdata;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk65 or negedge rst_n) begin
    if (!rst_n)                 underflow <= 1'b0;
    else if (active && empty)   underflow <= 1'b1;
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter: RAM model word = address, pixel scoreboard queue.
module tb_vga_fb_arbiter;
  import vga_pkg::*;

  localparam int H = 20;
  localparam int V = 30;
  localparam int AW = 10;
  localparam int DEPTH = 4;
  localparam int LW = 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          active;
  logic          screenend;
  logic [23:0]   color_out;
  logic          underflow;
  logic          host_req;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [23:0]   host_wdata;
  logic          host_ack;
  logic [23:0]   host_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [23:0]   mem_wdata;
  logic [23:0]   mem_rdata;
  state_t        fsm_state;

  vga_fb_arbiter #(
    .H_VISIBLE(H), .V_VISIBLE(V), .ADDR_W(AW), .FIFO_DEPTH(DEPTH), .LOW_WATER(LW),
    .UNDERFLOW_COLOR(24'hFF00FF)
  ) dut (
    .clk65(clk), .rst_n(rst_n), .active(active), .screenend(screenend),
    .color_out(color_out), .underflow(underflow),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rdata(host_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .fsm_state(fsm_state)
  );

  // clock / reset block
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // synchronous RAM model, contents initialised to word = address
  logic [23:0] ram [1024];
  bit ram_init = 1'b0;
  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < 1024; i++) ram[i] <= 24'(i);
      ram_init <= 1'b1;
    end else if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
    mem_rdata <= ram[mem_addr];
  end

  // scoreboard
  int passed = 0;
  int total = 0;
  logic [23:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  int exp_fetch = 0;
  int disp_cnt = 0;
  int first_disp = 0;
  int last_disp = 0;
  int hrd1_cyc = 0;
  bit pix_chk = 1'b0;
  bit ack_in_active = 1'b0;

  always @(negedge clk) begin
    if (rst_n && fsm_state == DISP) begin
      check("disp_addr", 32'(mem_addr), 32'(exp_fetch));
      exp_fetch++;
      if (disp_cnt == 0) first_disp = cyc;
      last_disp = cyc;
      disp_cnt++;
    end
    if (fsm_state == HRD1) hrd1_cyc = cyc;
    if (host_ack && active) ack_in_active = 1'b1;
    if (rst_n && active && pix_chk) begin
      check("pix_avail", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) check("pixel", color_out, exp_q.pop_front());
    end
  end

  // driver tasks
  int          snap_wait;
  logic        snap_we;
  logic [AW-1:0] snap_addr;
  logic [23:0] snap_wdata;
  logic [23:0] snap_rdata;
  int          ack_cyc;

  task automatic host_op(input logic we, input logic [AW-1:0] addr, input logic [23:0] wdata);
    int n;
    @(posedge clk); #1;
    host_req = 1'b1; host_we = we; host_addr = addr; host_wdata = wdata;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!host_ack && n < 200);
    check("host_ack_seen", host_ack, 1);
    snap_wait  = n;
    snap_we    = mem_we;
    snap_addr  = mem_addr;
    snap_wdata = mem_wdata;
    snap_rdata = host_rdata;
    ack_cyc    = cyc;
    host_req   = 1'b0;
  endtask

  task automatic drive_active(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      active = 1'b1;
    end
    @(posedge clk); #1;
    active = 1'b0;
  endtask

  task automatic expect_pixels(input int base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(24'(base + i));
  endtask

  initial begin
    rst_n = 1'b0; active = 1'b0; screenend = 1'b0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_host_ack", host_ack, 0);
    check("rst_host_rdata", host_rdata, 0);
    check("rst_underflow", underflow, 0);
    check("rst_state", fsm_state, IDLE);

    // boot refill: four consecutive reads from address 0, then idle
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("boot_reads", 32'(disp_cnt), 4);
    check("boot_consecutive", 32'(last_disp - first_disp), 3);
    check("boot_idle", fsm_state, IDLE);
    check("boot_underflow", underflow, 0);
    check("boot_black", color_out, 0);

    // first visible line
    pix_chk = 1'b1;
    expect_pixels(0, H);
    drive_active(H);
    repeat (8) @(negedge clk);
    check("line1_drained", 32'(exp_q.size()), 0);
    check("line1_underflow", underflow, 0);

    // host write then read-back in blanking
    host_op(1'b1, 10'd5, 24'hABCDEF);
    check("hwr_we", snap_we, 1);
    check("hwr_addr", 32'(snap_addr), 5);
    check("hwr_wdata", snap_wdata, 24'hABCDEF);
    @(negedge clk);
    check("hwr_we_one_cycle", mem_we, 0);
    host_op(1'b0, 10'd5, 24'h0);
    check("hrd_data", snap_rdata, 24'hABCDEF);
    check("hrd_latency", 32'(ack_cyc - hrd1_cyc), 2);

    // host request raised with the start of a line waits for blanking
    repeat (6) @(negedge clk);
    ack_in_active = 1'b0;
    expect_pixels(H, H);
    fork
      host_op(1'b1, 10'd100, 24'h123456);
      drive_active(H);
    join
    check("no_ack_in_active", ack_in_active, 0);
    check("ack_after_line", 32'(snap_wait > H), 1);
    check("line2_drained", 32'(exp_q.size()), 0);
    check("line2_underflow", underflow, 0);
    host_op(1'b0, 10'd100, 24'h0);
    check("hwr2_readback", snap_rdata, 24'h123456);

    // screenend while display reads are in flight
    repeat (8) @(negedge clk);
    expect_pixels(2 * H, 3);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      active = 1'b1;
    end
    @(posedge clk); #1;
    active = 1'b0; screenend = 1'b1;
    @(posedge clk); #1;
    screenend = 1'b0; exp_fetch = 0; disp_cnt = 0;
    repeat (10) @(negedge clk);
    check("flush_refill_reads", 32'(disp_cnt), 4);
    check("flush_q_drained", 32'(exp_q.size()), 0);
    expect_pixels(0, 4);
    drive_active(4);
    repeat (2) @(negedge clk);
    check("frame2_drained", 32'(exp_q.size()), 0);
    check("frame2_underflow", underflow, 0);

    // underflow: active straight out of reset with an empty FIFO
    @(posedge clk); #1;
    rst_n = 1'b0; pix_chk = 1'b0;
    repeat (2) @(negedge clk);
    check("rst2_underflow", underflow, 0);
    @(posedge clk); #1;
    exp_fetch = 0;
    rst_n = 1'b1; active = 1'b1;
    @(negedge clk);
    check("uf_color", color_out, 24'hFF00FF);
    @(negedge clk);
    check("uf_flag", underflow, 1);
    @(posedge clk); #1;
    active = 1'b0;
    @(negedge clk);
    check("inactive_black", color_out, 0);
    @(posedge clk); #1;
    screenend = 1'b1;
    @(posedge clk); #1;
    screenend = 1'b0; exp_fetch = 0;
    repeat (8) @(negedge clk);
    check("uf_sticky", underflow, 1);

    // final report
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
